regfile_sweep: RTL and testbench



---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_sweep_if.sv | 26 ++
 rtl/regfile_clear_seq.sv | 41 ++++
 rtl/regfile_sweep.sv | 74 +++++++
 tb/tb_regfile_sweep.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the two-read/one-write register file with clear sweep.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } sweepState_e;

    localparam int REGFILE_DATA_WIDTH = 32;
    localparam int REGFILE_ADDR_WIDTH = 5;
    localparam int ZERO_REG           = 0;

endpackage

// File: rtl/regfile_sweep_if.sv
// Decode/writeback side of the register file: two read ports, one write port, Ready status.
interface regfile_sweep_if #(
    parameter int DATA_WIDTH = regfile_pkg::REGFILE_DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::REGFILE_ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0] ReadRegister1;
    logic [ADDR_WIDTH-1:0] ReadRegister2;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;
    logic [ADDR_WIDTH-1:0] WriteRegister;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  RegWrite;
    logic                  Ready;

    modport master (
        output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
        input  ReadData1, ReadData2, Ready
    );

    modport slave (
        input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
        output ReadData1, ReadData2, Ready
    );

endinterface

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every array index once, then parks in RUN with ready high.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    output logic                  clearEn,
    output logic [ADDR_WIDTH-1:0] clearIdx,
    output logic                  ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    sweepState_e state;

    // RUN is terminal; only a reset brings the sweep back to entry 0.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= CLEAR;
            clearIdx <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clearIdx <= clearIdx + ADDR_WIDTH'(1);
                    if (clearIdx == LAST_IDX) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                end
            endcase
        end
    end

    assign clearEn = (state == CLEAR);

endmodule

// File: rtl/regfile_sweep.sv
// MIPS register file: 2 combinational reads, 1 write, r0 hardwired to zero, swept clear after reset.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto a matching read port.
module regfile_sweep
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
    parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH
) (
    input logic          Clk,
    input logic          Reset_n,
    regfile_sweep_if.slave bus
);

    localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  clearEn;
    logic [ADDR_WIDTH-1:0] clearIdx;
    logic                  ready;
    logic                  userWrite;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;

    regfile_clear_seq #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) clearSeq (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clearEn (clearEn),
        .clearIdx(clearIdx),
        .ready   (ready)
    );

    assign userWrite = ready && bus.RegWrite && (bus.WriteRegister != ZERO_IDX);

    // The array has no reset; the sweep owns the write port until ready rises.
    always_ff @(posedge Clk) begin
        if (clearEn) begin
            regs[clearIdx] <= '0;
        end else if (userWrite) begin
            regs[bus.WriteRegister] <= bus.WriteData;
        end
    end

    always_comb begin
        readData1 = '0;
        if (ready && (bus.ReadRegister1 != ZERO_IDX)) begin
            readData1 = regs[bus.ReadRegister1];
`ifdef REGFILE_BYPASS_EN
            if (userWrite && (bus.WriteRegister == bus.ReadRegister1)) begin
                readData1 = bus.WriteData;
            end
`endif
        end
    end

    always_comb begin
        readData2 = '0;
        if (ready && (bus.ReadRegister2 != ZERO_IDX)) begin
            readData2 = regs[bus.ReadRegister2];
`ifdef REGFILE_BYPASS_EN
            if (userWrite && (bus.WriteRegister == bus.ReadRegister2)) begin
                readData2 = bus.WriteData;
            end
`endif
        end
    end

    assign bus.ReadData1 = readData1;
    assign bus.ReadData2 = readData2;
    assign bus.Ready     = ready;

endmodule

// File: tb/tb_regfile_sweep.sv
// Self-checking bench for regfile_sweep: directed sequences plus random traffic against a reference model.
module tb_regfile_sweep;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rstN;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: register contents and the number of edges since reset was released.
    logic [DW-1:0] model [DEPTH];
    bit            modelReady;
    int            sweepEdges;

    regfile_sweep_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    regfile_sweep #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .Clk    (clk),
        .Reset_n(rstN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [DW-1:0] expectedRead(input logic [AW-1:0] idx);
        if (!modelReady || idx == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (bus.RegWrite && bus.WriteRegister == idx) return bus.WriteData;
`endif
        return model[idx];
    endfunction

    // Drive one cycle from a falling edge: check reads before the rising edge, then advance the model.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] wReg, input logic [DW-1:0] wData,
                                 input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        bus.RegWrite      = we;
        bus.WriteRegister = wReg;
        bus.WriteData     = wData;
        bus.ReadRegister1 = r1;
        bus.ReadRegister2 = r2;
        #1;
        checkOutput("ready", DW'(bus.Ready), DW'(modelReady));
        checkOutput("rd1", bus.ReadData1, expectedRead(r1));
        checkOutput("rd2", bus.ReadData2, expectedRead(r2));
        @(posedge clk);
        if (modelReady) begin
            if (we && wReg != '0) model[wReg] = wData;
        end else begin
            sweepEdges++;
            if (sweepEdges == DEPTH) begin
                modelReady = 1'b1;
                foreach (model[i]) model[i] = '0;
            end
        end
        @(negedge clk);
    endtask

    task automatic randomCycle();
        logic [AW-1:0] w;
        logic [AW-1:0] r1;
        w  = AW'($urandom_range(0, DEPTH - 1));
        r1 = ($urandom_range(0, 1) == 1) ? w : AW'($urandom_range(0, DEPTH - 1));
        applyStimulus(1'($urandom_range(0, 1)), w, $urandom, r1, AW'($urandom_range(0, DEPTH - 1)));
    endtask

    // Assert reset asynchronously, hold it for a few edges, release it just after a falling edge.
    task automatic doReset(input int holdEdges);
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = '0;
        bus.WriteData     = '0;
        bus.ReadRegister1 = AW'(8);
        bus.ReadRegister2 = AW'(9);
        rstN = 1'b0;
        #1;
        checkOutput("rstReady", DW'(bus.Ready), '0);
        checkOutput("rstRd1", bus.ReadData1, '0);
        checkOutput("rstRd2", bus.ReadData2, '0);
        modelReady = 1'b0;
        sweepEdges = 0;
        repeat (holdEdges) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic sweepWithTraffic();
        for (int c = 1; c <= DEPTH; c++) randomCycle();
    endtask

    initial begin
        rstN = 1'b1;
        foreach (model[i]) model[i] = '0;
        modelReady = 1'b0;
        sweepEdges = 0;
        #2;
        doReset(3);

        // Sweep with a stray write to r10 on edge 5, then confirm it was dropped.
        for (int c = 1; c <= DEPTH; c++) begin
            if (c == 5) applyStimulus(1'b1, AW'(10), 32'h0000_0055, AW'(10), AW'(8));
            else        randomCycle();
        end
        checkOutput("readyAfterSweep", DW'(bus.Ready), 32'd1);
        applyStimulus(1'b0, '0, '0, AW'(8), AW'(9));
        applyStimulus(1'b0, '0, '0, AW'(10), AW'(10));

        for (int i = 8; i <= 25; i++) applyStimulus(1'b1, AW'(i), DW'(i + 32'h100), AW'(0), AW'(31));
        for (int i = 8; i <= 24; i += 2) begin
            applyStimulus(1'b0, '0, '0, AW'(i), AW'(i + 1));
            checkOutput("pairLo", bus.ReadData1, DW'(i + 32'h100));
            checkOutput("pairHi", bus.ReadData2, DW'(i + 32'h101));
        end

        applyStimulus(1'b1, AW'(0), 32'hDEAD_BEEF, AW'(0), AW'(0));
        applyStimulus(1'b0, '0, '0, AW'(0), AW'(0));

        // Collision on r12 with a known old value.
        applyStimulus(1'b1, AW'(12), 32'h1111_2222, AW'(1), AW'(2));
        applyStimulus(1'b1, AW'(12), 32'hAAAA_5555, AW'(12), AW'(13));
        applyStimulus(1'b0, '0, '0, AW'(12), AW'(12));
        checkOutput("collisionAfter", bus.ReadData1, 32'hAAAA_5555);

        repeat (300) randomCycle();

        // Reset landing mid-sweep at edge 16 restarts the full sweep.
        doReset(2);
        for (int c = 1; c <= 16; c++) randomCycle();
        doReset(1);
        sweepWithTraffic();
        applyStimulus(1'b1, AW'(20), 32'h0000_1234, AW'(20), AW'(0));
        applyStimulus(1'b0, '0, '0, AW'(20), AW'(21));
        checkOutput("r20Written", bus.ReadData1, 32'h0000_1234);

        // Reset during RUN clears r20 again after a fresh sweep.
        doReset(2);
        sweepWithTraffic();
        applyStimulus(1'b0, '0, '0, AW'(20), AW'(12));
        checkOutput("r20Cleared", bus.ReadData1, '0);
        repeat (100) randomCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
